// File: rtl/res_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// res_bcd_converter_if : divider-result / BCD-result bundle
// Rev 1.0
// ============================================================================
interface res_bcd_converter_if #(
    parameter int WIDTH = 12
);
    logic             Ready;
    logic [WIDTH-1:0] Res;
    logic             Busy;
    logic             Valid;
    logic [15:0]      Bcd;
    logic [3:0]       Blank;

    modport master (
        output Ready, Res,
        input  Busy, Valid, Bcd, Blank
    );

    modport slave (
        input  Ready, Res,
        output Busy, Valid, Bcd, Blank
    );
endinterface
`default_nettype wire

// File: rtl/res_bcd_converter.sv
`default_nettype none
// ============================================================================
// res_bcd_converter : sequential double-dabble, 12-bit binary -> 4 BCD digits
// Rev 1.0
// ============================================================================
module res_bcd_converter #(
    parameter int WIDTH = 12
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    res_bcd_converter_if.slave    bus
);

    localparam int         c_SCR_W     = 16 + WIDTH;
    localparam logic [3:0] c_LAST_SHIFT = 4'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADJ   = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ready_q;
    logic [c_SCR_W-1:0] r_scratch;
    logic [c_SCR_W-1:0] w_scratch_adj;
    logic [c_SCR_W-1:0] w_scratch_nxt;
    logic [3:0]         r_count;
    logic [3:0]         w_count_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_nxt;
    logic [3:0]         r_blank;
    logic [3:0]         w_blank_nxt;
    logic [15:0]        w_bcd_res;
    logic [3:0]         w_blank_res;
    logic               w_start;

    // Rising edge of Ready, only honoured from IDLE; ready_q tracks regardless.
    assign w_start = (r_state == S_IDLE) && bus.Ready && !r_ready_q;

    assign w_scratch_adj[WIDTH-1:0] = r_scratch[WIDTH-1:0];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            logic [3:0] w_digit;
            assign w_digit = r_scratch[WIDTH + 4*gi +: 4];
            assign w_scratch_adj[WIDTH + 4*gi +: 4] =
                (w_digit >= 4'd5) ? (w_digit + 4'd3) : w_digit;
        end
    endgenerate

    assign w_bcd_res      = r_scratch[c_SCR_W-1 -: 16];
    assign w_blank_res[3] = (w_bcd_res[15:12] == 4'd0);
    assign w_blank_res[2] = w_blank_res[3] && (w_bcd_res[11:8] == 4'd0);
    assign w_blank_res[1] = w_blank_res[2] && (w_bcd_res[7:4] == 4'd0);
    assign w_blank_res[0] = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_ADJ;
            S_ADJ:   w_state_nxt = S_SHIFT;
            S_SHIFT: w_state_nxt = (r_count < c_LAST_SHIFT) ? S_ADJ : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_scratch_nxt = r_scratch;
        w_count_nxt   = r_count;
        w_busy_nxt    = r_busy;
        w_valid_nxt   = 1'b0;
        w_bcd_nxt     = r_bcd;
        w_blank_nxt   = r_blank;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_scratch_nxt = {16'd0, bus.Res};
                    w_count_nxt   = 4'd0;
                    w_busy_nxt    = 1'b1;
                end
            end
            S_ADJ: begin
                w_scratch_nxt = w_scratch_adj;
            end
            S_SHIFT: begin
                w_scratch_nxt = {r_scratch[c_SCR_W-2:0], 1'b0};
                w_count_nxt   = r_count + 4'd1;
            end
            S_DONE: begin
                w_bcd_nxt   = w_bcd_res;
                w_blank_nxt = w_blank_res;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // ready_q resets high so a Ready already asserted at release is not a start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready_q <= 1'b1;
            r_scratch <= '0;
            r_count   <= 4'd0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= 16'h0000;
            r_blank   <= 4'b1110;
        end else begin
            r_ready_q <= bus.Ready;
            r_scratch <= w_scratch_nxt;
            r_count   <= w_count_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_bcd     <= w_bcd_nxt;
            r_blank   <= w_blank_nxt;
        end
    end

    assign bus.Busy  = r_busy;
    assign bus.Valid = r_valid;
    assign bus.Bcd   = r_bcd;
    assign bus.Blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_res_bcd_converter.sv
`default_nettype none
// ============================================================================
// tb_res_bcd_converter : directed bench for res_bcd_converter
// Rev 1.0
// ============================================================================
module tb_res_bcd_converter;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    logic [15:0] exp_hold;

    res_bcd_converter_if #(.WIDTH(12)) bus ();

    res_bcd_converter #(.WIDTH(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a conversion on a fresh Ready edge and check the full timeline.
    task automatic convert(input logic [11:0] res, input logic [15:0] exp_bcd,
                           input logic [3:0] exp_blank, input string tag);
        @(negedge clk) bus.Ready = 1'b0;
        @(negedge clk) begin
            bus.Ready = 1'b1;
            bus.Res   = res;
        end
        @(posedge clk) #1;
        check({tag, " busy_at_start"}, 32'(bus.Busy), 32'd1);
        @(negedge clk) bus.Res = ~res;
        repeat (24) @(posedge clk);
        #1;
        check({tag, " valid_early"}, 32'(bus.Valid), 32'd0);
        check({tag, " busy_mid"}, 32'(bus.Busy), 32'd1);
        check({tag, " bcd_hold"}, 32'(bus.Bcd), 32'(exp_hold));
        @(posedge clk) #1;
        check({tag, " valid"}, 32'(bus.Valid), 32'd1);
        check({tag, " busy_done"}, 32'(bus.Busy), 32'd0);
        check({tag, " bcd"}, 32'(bus.Bcd), 32'(exp_bcd));
        check({tag, " blank"}, 32'(bus.Blank), 32'(exp_blank));
        @(posedge clk) #1;
        check({tag, " valid_pulse"}, 32'(bus.Valid), 32'd0);
        exp_hold = exp_bcd;
        @(negedge clk) bus.Ready = 1'b0;
    endtask

    initial begin
        int vcnt;
        int bcnt;
        logic [15:0] vbcd;

        n_vec     = 0;
        n_err     = 0;
        exp_hold  = 16'h0000;
        reset_n   = 1'b0;
        bus.Ready = 1'b0;
        bus.Res   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(bus.Busy), 32'd0);
        check("rst valid", 32'(bus.Valid), 32'd0);
        check("rst bcd", 32'(bus.Bcd), 32'h0000);
        check("rst blank", 32'(bus.Blank), 32'b1110);
        @(negedge clk) reset_n = 1'b1;

        convert(12'd0,    16'h0000, 4'b1110, "res0");
        convert(12'd4095, 16'h4095, 4'b0000, "res4095");
        convert(12'd305,  16'h0305, 4'b1000, "res305");
        convert(12'd7,    16'h0007, 4'b1110, "res7");
        convert(12'd1000, 16'h1000, 4'b0000, "res1000");

        // Retrigger during a conversion is dropped; Ready held high gives one result.
        @(negedge clk) bus.Ready = 1'b0;
        @(negedge clk) begin
            bus.Ready = 1'b1;
            bus.Res   = 12'd100;
        end
        @(posedge clk);
        repeat (4) @(negedge clk);
        bus.Ready = 1'b0;
        @(negedge clk) begin
            bus.Ready = 1'b1;
            bus.Res   = 12'd999;
        end
        vcnt = 0;
        vbcd = 16'hFFFF;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk) #1;
            if (bus.Valid === 1'b1) begin
                vcnt++;
                vbcd = bus.Bcd;
            end
        end
        check("retrig valid_count", 32'(vcnt), 32'd1);
        check("retrig bcd", 32'(vbcd), 32'h0100);
        check("retrig bcd_final", 32'(bus.Bcd), 32'h0100);

        // Abort mid-conversion with reset.
        @(negedge clk) bus.Ready = 1'b0;
        @(negedge clk) begin
            bus.Ready = 1'b1;
            bus.Res   = 12'd4095;
        end
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("abort busy", 32'(bus.Busy), 32'd0);
        check("abort valid", 32'(bus.Valid), 32'd0);
        check("abort bcd", 32'(bus.Bcd), 32'h0000);
        check("abort blank", 32'(bus.Blank), 32'b1110);
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        vcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk) #1;
            if (bus.Valid !== 1'b0) vcnt++;
            if (bus.Busy !== 1'b0) bcnt++;
        end
        check("post_rst valid_count", 32'(vcnt), 32'd0);
        check("post_rst busy_count", 32'(bcnt), 32'd0);
        check("post_rst bcd", 32'(bus.Bcd), 32'h0000);
        exp_hold = 16'h0000;

        convert(12'd42, 16'h0042, 4'b1100, "res42");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/res_bcd_converter.md
RES_BCD_CONVERTER -- requirements
Module: res_bcd_converter

Interface
REQ-001 Parameter: WIDTH, default 12, binary input width; this block is defined and verified only for WIDTH=12, giving 4 BCD digits.
REQ-002 Port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1, asynchronous, active-low reset.
REQ-004 Port Ready, input, 1, result-ready flag from the upstream divider; it may stay high for many cycles.
REQ-005 Port Res, input, WIDTH, unsigned quotient from the divider; valid whenever Ready=1.
REQ-006 Port Busy, output, 1, high while a conversion is in progress.
REQ-007 Port Valid, output, 1, one-cycle pulse marking new Bcd/Blank values.
REQ-008 Port Bcd, output, 16, packed digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 Port Blank, output, 4, leading-zero blank flag per digit, with the same digit order as Bcd ([3] = thousands).

Function
REQ-010 The block SHALL register Ready into ready_q on every clock, in every state.
REQ-011 A start event SHALL be Ready=1 with ready_q=0, sampled at a clock edge while state=IDLE.
REQ-012 Start events while the state is not IDLE SHALL be ignored and not queued; because ready_q still updates, such an edge is consumed.
REQ-013 Ready held high SHALL produce exactly one conversion.
REQ-014 The block SHALL use states IDLE, ADJ, SHIFT and DONE.
REQ-015 IDLE->ADJ on start event edge N: capture Res into a 28-bit scratch register {16'b0, Res}, count<=0, Busy<=1.
REQ-016 ADJ: each 4-bit BCD field of the scratch register that is >=5 SHALL have 3 added; next state SHIFT.
REQ-017 SHIFT: the scratch register SHALL shift left by 1 and count SHALL increment; the next state SHALL be ADJ if count<11, otherwise DONE.
REQ-018 DONE: Bcd<=scratch[27:12], Blank updated, Valid<=1, Busy<=0, next state IDLE.
REQ-019 Timing: 12 ADJ/SHIFT pairs occupy edges N+1..N+24, DONE executes at N+25, Valid is high for the single cycle following edge N+25, and the next start is accepted at edge N+26 or later.
REQ-020 Valid SHALL be deasserted on every edge except the DONE edge.
REQ-021 Bcd and Blank SHALL hold their last values until the next DONE; they SHALL NOT change during a conversion.
REQ-022 Blank[3] = (thousands==0).
REQ-023 Blank[2] = Blank[3] & (hundreds==0).
REQ-024 Blank[1] = Blank[2] & (tens==0).
REQ-025 Blank[0] = 0 always, so the ones digit is never blanked.
REQ-026 Every Bcd digit SHALL be in the range 0..9 for all inputs 0..4095; no saturation or overflow path exists.
REQ-027 Res SHALL be sampled only at the start edge; changes on Res after that edge SHALL NOT affect the result.

Reset
REQ-028 reset_n=0 SHALL immediately force: state=IDLE, Busy=0, Valid=0, Bcd=16'h0000, Blank=4'b1110, count=0, scratch=0.
REQ-029 reset_n=0 SHALL force ready_q=1, so Ready already high at reset release does not start a conversion.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion; no Valid pulse or Bcd update from it SHALL occur.
REQ-031 After reset release, the first start event SHALL require a fresh 0->1 transition on Ready.

Verification
REQ-032 Res=0, Ready rises at edge N -> at N+25 Bcd=16'h0000, Blank=4'b1110, Valid high one cycle, Busy high over N..N+24.
REQ-033 Res=4095 -> Bcd=16'h4095, Blank=4'b0000.
REQ-034 Res=305 -> Bcd=16'h0305, Blank=4'b1000.
REQ-035 Res=7 -> Bcd=16'h0007, Blank=4'b1110.
REQ-036 Res=100 converting; Ready toggles 0->1 at N+5 with Res=999 -> single result 16'h0100, no second Valid; Ready held high 100 cycles -> exactly one Valid.
REQ-037 Res=4095, reset_n pulsed low at N+10 -> outputs at reset values, no Valid, Bcd stays 16'h0000.
REQ-038 After REQ-037, Ready still high on reset release -> no conversion.
REQ-039 After REQ-038, a Ready 0->1 transition with Res=42 -> Bcd=16'h0042 exactly 25 cycles after the start edge.
